// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencing controller.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } state_e;

  localparam int DEF_CNT_W = 16;

  // PC is a word address, so the next sequential instruction is +1.
  localparam logic [31:0] PC_INC = 32'd1;

  // Width of the shared boot/flush sequence counter.
  localparam int SEQ_W = 8;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle between the fetch controller and the rest of the pipeline.
// master = the controller, slave = pipeline/fetch unit side.
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             stall_req;
  logic             br_taken;
  logic [31:0]      br_target;
  logic             halt_req;
  logic             resume;
  logic [31:0]      pc;
  logic [31:0]      pc_nxt;

  logic             sel_pc;
  logic [31:0]      pc_in_pc;
  logic [31:0]      pc_in_alu;
  logic             if_valid;
  logic             stall_if;
  logic             flush_ifid;
  logic             flush_idex;
  logic [2:0]       state_dbg;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  stall_req, br_taken, br_target, halt_req, resume, pc, pc_nxt,
    output sel_pc, pc_in_pc, pc_in_alu, if_valid, stall_if, flush_ifid,
           flush_idex, state_dbg, redirect_cnt, stall_cnt
  );

  modport slave (
    output stall_req, br_taken, br_target, halt_req, resume, pc, pc_nxt,
    input  sel_pc, pc_in_pc, pc_in_alu, if_valid, stall_if, flush_ifid,
           flush_idex, state_dbg, redirect_cnt, stall_cnt
  );

endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter
  import fetch_ctrl_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count one per asserted inc, holding once every bit is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: chooses the next PC source every cycle and
// handles boot delay, load-use stalls, redirects with flushes, and halt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES  = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);

  localparam logic [SEQ_W-1:0] BOOT_LAST  = SEQ_W'(BOOT_CYCLES - 1);
  localparam logic [SEQ_W-1:0] FLUSH_LAST = SEQ_W'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] seqCnt_q, seqCnt_d;

  logic        redirect;
  logic        selPc;
  logic [31:0] pcInPc;
  logic        ifValid;
  logic        stallIf;
  logic        flushIfid;
  logic        flushIdex;
  logic        redirectInc;
  logic        stallInc;
  logic [CNT_W-1:0] redirectCnt;
  logic [CNT_W-1:0] stallCnt;

  // Next-state and output decode; a redirect in RUN/STALL/FLUSH beats everything.
  always_comb begin
    state_d     = state_q;
    seqCnt_d    = seqCnt_q;
    selPc       = 1'b0;
    pcInPc      = bus.pc;
    ifValid     = 1'b0;
    stallIf     = 1'b0;
    flushIfid   = 1'b0;
    flushIdex   = 1'b0;
    redirectInc = 1'b0;
    stallInc    = 1'b0;

    redirect = bus.br_taken &&
               ((state_q == RUN) || (state_q == STALL) || (state_q == FLUSH));

    if (redirect) begin
      selPc       = 1'b1;
      flushIfid   = 1'b1;
      flushIdex   = 1'b1;
      redirectInc = 1'b1;
      if (FLUSH_CYCLES == 1) begin
        state_d  = RUN;
        seqCnt_d = '0;
      end else begin
        state_d  = FLUSH;
        seqCnt_d = FLUSH_LAST;
      end
    end else begin
      case (state_q)
        BOOT: begin
          if (seqCnt_q == BOOT_LAST) begin
            state_d  = RUN;
            seqCnt_d = '0;
          end else begin
            seqCnt_d = seqCnt_q + 1'b1;
          end
        end
        RUN: begin
          if (bus.halt_req) begin
            state_d = HALT;
          end else if (bus.stall_req) begin
            stallIf   = 1'b1;
            flushIdex = 1'b1;
            ifValid   = 1'b1;
            stallInc  = 1'b1;
            state_d   = STALL;
          end else begin
            pcInPc  = bus.pc_nxt;
            ifValid = 1'b1;
          end
        end
        STALL: begin
          ifValid = 1'b1;
          if (bus.stall_req) begin
            stallIf   = 1'b1;
            flushIdex = 1'b1;
            stallInc  = 1'b1;
          end else begin
            pcInPc  = bus.pc_nxt;
            state_d = RUN;
          end
        end
        FLUSH: begin
          pcInPc = bus.pc_nxt;
          if (seqCnt_q <= SEQ_W'(1)) begin
            state_d  = RUN;
            seqCnt_d = '0;
          end else begin
            seqCnt_d = seqCnt_q - 1'b1;
          end
        end
        HALT: begin
          if (bus.resume) begin
            pcInPc  = bus.pc_nxt;
            ifValid = 1'b1;
            state_d = RUN;
          end
        end
        default: begin
          state_d  = BOOT;
          seqCnt_d = '0;
        end
      endcase
    end
  end

  // State and sequence counter; reset drops straight back into BOOT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      seqCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      seqCnt_q <= seqCnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) uRedirectCnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (redirectInc),
    .cnt_o (redirectCnt)
  );

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stallInc),
    .cnt_o (stallCnt)
  );

  assign bus.sel_pc       = selPc;
  assign bus.pc_in_pc     = pcInPc;
  assign bus.pc_in_alu    = bus.br_target;
  assign bus.if_valid     = ifValid;
  assign bus.stall_if     = stallIf;
  assign bus.flush_ifid   = flushIfid;
  assign bus.flush_idex   = flushIdex;
  assign bus.state_dbg    = state_q;
  assign bus.redirect_cnt = redirectCnt;
  assign bus.stall_cnt    = stallCnt;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the fetch unit (PC register plus instruction memory) in the rv32 pipeline. It drives the PC select signal and both PC input paths every cycle. It also handles boot delay after reset, load-use stalls, branch/jump redirects with pipeline-register flushes, and halt/resume. Two saturating performance counters track redirects and stall cycles.

Parameters:
BOOT_CYCLES, 2, cycles after reset deassertion before the first fetched instruction is marked valid (min 1)
FLUSH_CYCLES, 2, bubble cycles marked invalid after a redirect, including the redirect cycle (min 1)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall_req  in  1  load-use hazard from decode; hold PC
br_taken  in  1  execute-stage taken branch/jump
br_target  in  32  redirect target, word address
halt_req  in  1  ecall/ebreak seen in decode
resume  in  1  leave HALT
pc  in  32  current PC from fetch unit
pc_nxt  in  32  pc+1 from fetch unit
sel_pc  out  1  to fetch unit; 1 = load pc_in_alu
pc_in_pc  out  32  to fetch unit in_pc (hold or advance value)
pc_in_alu  out  32  to fetch unit in_alu (redirect value)
if_valid  out  1  instruction leaving fetch this cycle is valid
stall_if  out  1  freeze IF/ID register
flush_ifid  out  1  squash IF/ID register
flush_idex  out  1  squash ID/EX register
state_dbg  out  3  current FSM state encoding
redirect_cnt  out  CNT_W  count of accepted redirects, saturating
stall_cnt  out  CNT_W  count of stall cycles, saturating

Behaviour:
- FSM states: BOOT, RUN, STALL, FLUSH, HALT. On reset: state=BOOT, internal counter=0, redirect_cnt=stall_cnt=0.
- Outputs are combinational from state and inputs. Reset values: sel_pc=0, pc_in_pc=pc, pc_in_alu=br_target, if_valid=0, stall_if=0, flush_ifid=0, flush_idex=0, state_dbg=BOOT.
- pc_in_alu always equals br_target. pc_in_pc is pc_nxt when advancing and pc when holding.
- BOOT: hold PC (pc_in_pc=pc, sel_pc=0), if_valid=0. Count BOOT_CYCLES cycles, then go to RUN. All requests are ignored.
- RUN, priority br_taken > halt_req > stall_req > advance:
  - Redirect: same cycle, sel_pc=1, flush_ifid=1, flush_idex=1, if_valid=0, redirect_cnt+1. Next state is FLUSH with counter=FLUSH_CYCLES-1, or RUN directly if FLUSH_CYCLES=1.
  - Halt: hold PC, if_valid=0, next state HALT.
  - Stall: hold PC, stall_if=1, flush_idex=1 (bubble into EX), if_valid=1 (IF/ID retains its content), stall_cnt+1, next state STALL.
  - Advance: pc_in_pc=pc_nxt, if_valid=1.
- STALL: same outputs as a RUN stall while stall_req=1. When stall_req drops, advance this cycle and return to RUN. br_taken in STALL overrides using the RUN redirect behaviour.
- FLUSH: advance PC (pc_in_pc=pc_nxt), if_valid=0, decrement counter; at 0 go to RUN. br_taken in FLUSH is accepted: redirect outputs, counter reloads to FLUSH_CYCLES-1, redirect_cnt+1. stall_req and halt_req are ignored in FLUSH.
- HALT: hold PC, if_valid=0. resume=1 gives an advance cycle, then RUN. br_taken is ignored in HALT. halt_req and resume both high in HALT: resume wins.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-operation forces BOOT immediately and asynchronously. Outputs take their reset values the same cycle.

Decomposition:
- Shared package fetch_ctrl_pkg holds:
  - the state enum encodings: BOOT=0, RUN=1, STALL=2, FLUSH=3, HALT=4
  - CNT_W default
  - the word-address increment constant (1)
- Sub-module sat_counter (width param, inc, async rst) is instantiated twice for redirect_cnt and stall_cnt.

Test Plan:
- Reset then release, no requests, pc tracking 0,1,2,… → if_valid=0 for exactly 2 cycles, then 1; pc_in_pc=pc_nxt from cycle 3; state_dbg BOOT→RUN.
- In RUN at pc=5, br_taken=1 with br_target=0x40 for one cycle → that cycle sel_pc=1, pc_in_alu=0x40, both flushes=1; if_valid=0 for 2 cycles; redirect_cnt=1.
- stall_req high 3 cycles at pc=7 → pc_in_pc=7 for 3 cycles, stall_if=1, flush_idex=1, stall_cnt=3; pc_in_pc=pc_nxt when stall_req drops.
- br_taken during the second FLUSH cycle, then br_taken together with stall_req in RUN → counter reloads; redirect wins over stall; redirect_cnt increments twice, stall_cnt unchanged.
- halt_req in RUN, hold 5 cycles, then resume with halt_req=1 → if_valid=0 and PC held while halted; resume wins; one advance cycle, then RUN.
- CNT_W=2, 5 redirects → redirect_cnt saturates at 3; rst asserted mid-FLUSH → immediate BOOT, counters=0.
